// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, the imem request handshake, a one-entry skid
// buffer for stalls, and prioritized redirects. Exception/eret redirects are enabled by FETCH_EXC_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] EXC_VEC  = 32'h0040_0004
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_stall,
  input  logic        in_br_taken,
  input  logic [31:0] in_br_target,
  input  logic        in_jmp,
  input  logic [31:0] in_jmp_target,
  input  logic        in_exc,
  input  logic        in_eret,
  input  logic [31:0] in_epc,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_ack,
  input  logic [31:0] in_imem_rdata,
  output logic [31:0] out_inst,
  output logic [31:0] out_inst_pc,
  output logic        out_inst_valid,
  output logic [31:0] out_pc,
  output logic        out_flush
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, drain_addr_reg;
  logic [31:0] inst_reg, inst_pc_reg;
  logic [31:0] skid_inst_reg, skid_pc_reg;
  logic        valid_reg, flush_reg;
  logic        redirect;
  logic [31:0] target_raw, redirect_target;

  always_comb begin
    redirect   = 1'b0;
    target_raw = '0;
`ifdef FETCH_EXC_EN
    if (in_exc) begin
      redirect   = 1'b1;
      target_raw = EXC_VEC;
    end else if (in_eret) begin
      redirect   = 1'b1;
      target_raw = in_epc;
    end else if (in_jmp) begin
      redirect   = 1'b1;
      target_raw = in_jmp_target;
    end else if (in_br_taken) begin
      redirect   = 1'b1;
      target_raw = in_br_target;
    end
`else
    if (in_jmp) begin
      redirect   = 1'b1;
      target_raw = in_jmp_target;
    end else if (in_br_taken) begin
      redirect   = 1'b1;
      target_raw = in_br_target;
    end
`endif
  end

`ifndef FETCH_EXC_EN
  logic unused_exc;
  assign unused_exc = ^{in_exc, in_eret, in_epc, EXC_VEC};
`endif

  assign redirect_target = target_raw & 32'hFFFF_FFFC;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) state_reg <= BOOT;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:  state_next = FETCH;
      FETCH: begin
        if (redirect)                      state_next = in_imem_ack ? FETCH : DRAIN;
        else if (in_imem_ack && in_stall)  state_next = HOLD;
      end
      HOLD:  if (redirect || !in_stall) state_next = FETCH;
      DRAIN: if (in_imem_ack) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  // Request/address depend only on state and registers, never on ack.
  always_comb begin
    out_imem_req  = 1'b0;
    out_imem_addr = pc_reg;
    case (state_reg)
      FETCH: out_imem_req = 1'b1;
      DRAIN: begin
        out_imem_req  = 1'b1;
        out_imem_addr = drain_addr_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      pc_reg         <= RESET_PC;
      drain_addr_reg <= '0;
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      skid_inst_reg  <= '0;
      skid_pc_reg    <= '0;
      valid_reg      <= 1'b0;
      flush_reg      <= 1'b0;
    end else begin
      flush_reg <= redirect;
      if (redirect) begin
        pc_reg        <= redirect_target;
        valid_reg     <= 1'b0;
        skid_inst_reg <= '0;
        skid_pc_reg   <= '0;
        if (state_reg == FETCH && !in_imem_ack) drain_addr_reg <= pc_reg;
      end else begin
        case (state_reg)
          FETCH: begin
            if (in_imem_ack) begin
              pc_reg <= pc_reg + 32'd4;
              if (in_stall) begin
                skid_inst_reg <= in_imem_rdata;
                skid_pc_reg   <= pc_reg;
              end else begin
                inst_reg    <= in_imem_rdata;
                inst_pc_reg <= pc_reg;
                valid_reg   <= 1'b1;
              end
            end else if (!in_stall) begin
              // Waiting on memory: present a bubble rather than repeat the last instruction.
              valid_reg <= 1'b0;
            end
          end
          HOLD: begin
            if (!in_stall) begin
              inst_reg    <= skid_inst_reg;
              inst_pc_reg <= skid_pc_reg;
              valid_reg   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_inst       = inst_reg;
  assign out_inst_pc    = inst_pc_reg;
  assign out_inst_valid = valid_reg;
  assign out_pc         = pc_reg;
  assign out_flush      = flush_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl; memory returns ~addr as the instruction word.
module tb_fetch_ctrl;

  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_stall = 1'b0;
  logic        in_br_taken = 1'b0;
  logic [31:0] in_br_target = '0;
  logic        in_jmp = 1'b0;
  logic [31:0] in_jmp_target = '0;
  logic        in_exc = 1'b0;
  logic        in_eret = 1'b0;
  logic [31:0] in_epc = '0;
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_ack = 1'b0;
  logic [31:0] in_imem_rdata;
  logic [31:0] out_inst;
  logic [31:0] out_inst_pc;
  logic        out_inst_valid;
  logic [31:0] out_pc;
  logic        out_flush;

  int tests = 0;
  int fails = 0;

  fetch_ctrl dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_stall(in_stall),
    .in_br_taken(in_br_taken), .in_br_target(in_br_target),
    .in_jmp(in_jmp), .in_jmp_target(in_jmp_target),
    .in_exc(in_exc), .in_eret(in_eret), .in_epc(in_epc),
    .out_imem_req(out_imem_req), .out_imem_addr(out_imem_addr),
    .in_imem_ack(in_imem_ack), .in_imem_rdata(in_imem_rdata),
    .out_inst(out_inst), .out_inst_pc(out_inst_pc), .out_inst_valid(out_inst_valid),
    .out_pc(out_pc), .out_flush(out_flush)
  );

  assign in_imem_rdata = ~out_imem_addr;

  always #5 in_clk = ~in_clk;

`ifdef FETCH_EXC_EN
  localparam logic [31:0] EV      = 32'h0040_0004;
  localparam logic [31:0] A19     = 32'h0040_0010;
  localparam logic        R18_V   = 1'b0;
  localparam logic        R18_F   = 1'b1;
  localparam logic [31:0] R18_IPC = 32'h0040_0004;
  localparam logic [31:0] R18_PC  = 32'h0040_0010;
`else
  localparam logic [31:0] EV      = 32'h0040_0200;
  localparam logic [31:0] A19     = 32'h0040_0208;
  localparam logic        R18_V   = 1'b1;
  localparam logic        R18_F   = 1'b0;
  localparam logic [31:0] R18_IPC = 32'h0040_0204;
  localparam logic [31:0] R18_PC  = 32'h0040_0208;
`endif

  typedef struct {
    logic ack, stall, jmp, br, exc, eret;
    logic [31:0] jt, bt, epc;
    logic e_req;
    logic [31:0] e_addr;
    logic e_valid;
    logic [31:0] e_ipc;
    logic e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t v(input logic ack, stall, jmp, input logic [31:0] jt,
                             input logic br, input logic [31:0] bt,
                             input logic exc, eret, input logic [31:0] epc,
                             input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_ipc,
                             input logic e_flush, input logic [31:0] e_pc);
    vec_t r;
    r.ack = ack; r.stall = stall; r.jmp = jmp; r.jt = jt; r.br = br; r.bt = bt;
    r.exc = exc; r.eret = eret; r.epc = epc;
    r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid; r.e_ipc = e_ipc;
    r.e_flush = e_flush; r.e_pc = e_pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ack, stall, jmp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt,
                       input logic exc, eret, input logic [31:0] epc);
    in_imem_ack = ack; in_stall = stall; in_jmp = jmp; in_jmp_target = jt;
    in_br_taken = br; in_br_target = bt; in_exc = exc; in_eret = eret; in_epc = epc;
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = v(1,0,0,0,0,0,0,0,0, 0,32'h0,        0,32'h0,        0,32'h0040_0000);
    tbl[1]  = v(1,0,0,0,0,0,0,0,0, 1,32'h0040_0000, 1,32'h0040_0000, 0,32'h0040_0004);
    tbl[2]  = v(1,0,0,0,0,0,0,0,0, 1,32'h0040_0004, 1,32'h0040_0004, 0,32'h0040_0008);
    tbl[3]  = v(1,1,0,0,0,0,0,0,0, 1,32'h0040_0008, 1,32'h0040_0004, 0,32'h0040_000C);
    tbl[4]  = v(1,1,0,0,0,0,0,0,0, 0,32'h0,        1,32'h0040_0004, 0,32'h0040_000C);
    tbl[5]  = v(1,1,0,0,0,0,0,0,0, 0,32'h0,        1,32'h0040_0004, 0,32'h0040_000C);
    tbl[6]  = v(1,0,0,0,0,0,0,0,0, 0,32'h0,        1,32'h0040_0008, 0,32'h0040_000C);
    tbl[7]  = v(1,0,0,0,0,0,0,0,0, 1,32'h0040_000C, 1,32'h0040_000C, 0,32'h0040_0010);
    tbl[8]  = v(0,0,1,32'h0040_0100,0,0,0,0,0, 1,32'h0040_0010, 0,32'h0040_000C, 1,32'h0040_0100);
    tbl[9]  = v(0,0,0,0,0,0,0,0,0, 1,32'h0040_0010, 0,32'h0040_000C, 0,32'h0040_0100);
    tbl[10] = v(1,0,0,0,0,0,0,0,0, 1,32'h0040_0010, 0,32'h0040_000C, 0,32'h0040_0100);
    tbl[11] = v(1,0,0,0,0,0,0,0,0, 1,32'h0040_0100, 1,32'h0040_0100, 0,32'h0040_0104);
    tbl[12] = v(1,0,1,32'h0040_0200,1,32'h0040_0300,0,0,0, 1,32'h0040_0104, 0,32'h0040_0100, 1,32'h0040_0200);
    tbl[13] = v(1,0,0,0,0,0,0,0,0, 1,32'h0040_0200, 1,32'h0040_0200, 0,32'h0040_0204);
    tbl[14] = v(1,0,0,0,1,32'h0040_0103,0,0,0, 1,32'h0040_0204, 0,32'h0040_0200, 1,32'h0040_0100);
    tbl[15] = v(1,0,0,0,0,0,0,0,0, 1,32'h0040_0100, 1,32'h0040_0100, 0,32'h0040_0104);
    tbl[16] = v(1,0,1,32'h0040_0200,0,0,1,0,0, 1,32'h0040_0104, 0,32'h0040_0100, 1,EV);
    tbl[17] = v(1,0,0,0,0,0,0,0,0, 1,EV, 1,EV, 0,EV + 32'd4);
    tbl[18] = v(1,0,0,0,0,0,0,1,32'h0040_0010, 1,EV + 32'd4, R18_V,R18_IPC, R18_F,R18_PC);
    tbl[19] = v(1,0,0,0,0,0,0,0,0, 1,A19, 1,A19, 0,A19 + 32'd4);
    tbl[20] = v(1,0,1,32'hFFFF_FFFC,0,0,0,0,0, 1,A19 + 32'd4, 0,A19, 1,32'hFFFF_FFFC);
    tbl[21] = v(1,0,0,0,0,0,0,0,0, 1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC, 0,32'h0);
    tbl[22] = v(1,0,0,0,0,0,0,0,0, 1,32'h0, 1,32'h0, 0,32'h4);

    // Reset with ack held high: nothing may be captured.
    in_rst_n = 1'b0;
    drive(1,0,0,0,0,0,0,0,0);
    tick(); tick();
    chk("reset req",   {31'b0, out_imem_req},   32'h0);
    chk("reset valid", {31'b0, out_inst_valid}, 32'h0);
    chk("reset flush", {31'b0, out_flush},      32'h0);
    chk("reset inst",  out_inst,    32'h0);
    chk("reset ipc",   out_inst_pc, 32'h0);
    chk("reset pc",    out_pc,      32'h0040_0000);
    in_rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].ack, tbl[i].stall, tbl[i].jmp, tbl[i].jt, tbl[i].br, tbl[i].bt,
            tbl[i].exc, tbl[i].eret, tbl[i].epc);
      chk($sformatf("row%0d req", i), {31'b0, out_imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("row%0d addr", i), out_imem_addr, tbl[i].e_addr);
      tick();
      chk($sformatf("row%0d valid", i), {31'b0, out_inst_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("row%0d ipc", i),   out_inst_pc, tbl[i].e_ipc);
      chk($sformatf("row%0d flush", i), {31'b0, out_flush}, {31'b0, tbl[i].e_flush});
      chk($sformatf("row%0d pc", i),    out_pc, tbl[i].e_pc);
      if (tbl[i].e_valid) chk($sformatf("row%0d inst", i), out_inst, ~tbl[i].e_ipc);
      $display("[TB] row %0d: addr=%h ipc=%h valid=%0d flush=%0d pc=%h",
               i, tbl[i].e_addr, out_inst_pc, out_inst_valid, out_flush, out_pc);
    end

    // Redirect while holding a skid entry: the skid instruction must be dropped.
    drive(1,1,0,0,0,0,0,0,0);
    chk("hold req", {31'b0, out_imem_req}, 32'h1);
    chk("hold addr", out_imem_addr, 32'h4);
    tick();
    chk("hold ipc", out_inst_pc, 32'h0);
    chk("hold pc",  out_pc, 32'h8);
    drive(0,1,0,0,1,32'h0040_0040,0,0,0);
    chk("hold idle req", {31'b0, out_imem_req}, 32'h0);
    tick();
    chk("hold redir flush", {31'b0, out_flush}, 32'h1);
    chk("hold redir valid", {31'b0, out_inst_valid}, 32'h0);
    chk("hold redir pc", out_pc, 32'h0040_0040);
    drive(0,0,0,0,0,0,0,0,0);
    chk("post-hold addr", out_imem_addr, 32'h0040_0040);
    tick();
    chk("post-hold flush", {31'b0, out_flush}, 32'h0);
    drive(1,0,0,0,0,0,0,0,0);
    tick();
    chk("post-hold valid", {31'b0, out_inst_valid}, 32'h1);
    chk("post-hold ipc", out_inst_pc, 32'h0040_0040);
    chk("post-hold inst", out_inst, ~32'h0040_0040);
    $display("[TB] redirect-in-hold: ipc=%h pc=%h", out_inst_pc, out_pc);

    // Reset with a request outstanding, then a late ack during BOOT.
    drive(0,0,0,0,0,0,0,0,0);
    tick();
    in_rst_n = 1'b0;
    tick();
    chk("midreset req", {31'b0, out_imem_req}, 32'h0);
    chk("midreset valid", {31'b0, out_inst_valid}, 32'h0);
    chk("midreset pc", out_pc, 32'h0040_0000);
    in_rst_n = 1'b1;
    drive(1,0,0,0,0,0,0,0,0);
    tick();
    chk("boot late ack valid", {31'b0, out_inst_valid}, 32'h0);
    chk("boot late ack pc", out_pc, 32'h0040_0000);
    chk("restart addr", out_imem_addr, 32'h0040_0000);
    tick();
    chk("restart valid", {31'b0, out_inst_valid}, 32'h1);
    chk("restart ipc", out_inst_pc, 32'h0040_0000);
    chk("restart pc", out_pc, 32'h0040_0004);
    $display("[TB] reset-mid-request: ipc=%h pc=%h", out_inst_pc, out_pc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the pipelined MIPS datapath. It owns the fetch program counter and the instruction-memory request handshake. It applies hazard-unit stalls and branch/jump/exception redirects with fixed priority, and presents one fetched instruction per cycle with its PC to the IF/ID stage. It sits between the hazard/branch logic and instruction memory, and replaces the bare PC register with a controller that sequences it.

## Interface
- RESET_PC, 32'h00400000, fetch address after reset
- EXC_VEC, 32'h00400004, exception handler entry address
- in_clk  input  1  clock; all logic on rising edge
- in_rst_n  input  1  reset, synchronous, active-low
- in_stall  input  1  hazard stall; freeze outputs, issue no new request
- in_br_taken  input  1  branch resolved taken
- in_br_target  input  32  branch target
- in_jmp  input  1  jump
- in_jmp_target  input  32  jump target
- in_exc  input  1  exception taken (macro-gated)
- in_eret  input  1  return from exception (macro-gated)
- in_epc  input  32  return address for eret (macro-gated)
- out_imem_req  output  1  memory request
- out_imem_addr  output  32  request address; stable while req high and no ack
- in_imem_ack  input  1  response valid; may arrive in the same cycle as req
- in_imem_rdata  input  32  instruction word, valid with ack
- out_inst  output  32  fetched instruction to IF/ID
- out_inst_pc  output  32  PC of out_inst
- out_inst_valid  output  1  out_inst is meaningful
- out_pc  output  32  next fetch PC register
- out_flush  output  1  one-cycle pulse on an accepted redirect

## Operation
- States: BOOT, FETCH, HOLD, DRAIN.
- BOOT: req=0. The state moves to FETCH on the next cycle.
- FETCH: req=1, addr=pc.
  - ack with in_stall=0: out_inst<=rdata, out_inst_pc<=pc, valid<=1, pc<=pc+4. The state stays FETCH.
  - ack with in_stall=1: rdata and pc are captured into a one-entry skid register, pc<=pc+4, and the state moves to HOLD. The IF/ID outputs stay frozen.
  - No ack: req and addr are held.
- HOLD: req=0. Outputs are frozen while in_stall=1. When in_stall=0, the skid entry moves to the outputs with valid=1, and the state moves to FETCH.
- A stall in FETCH with no outstanding request never occurs, because req is asserted in FETCH. The stall only determines where the data is routed.
- Redirect sources, priority high to low: in_exc (target EXC_VEC), in_eret (in_epc), in_jmp (in_jmp_target), in_br_taken (in_br_target).
- Redirect behaviour:
  - It is accepted regardless of in_stall.
  - pc<=target with bits [1:0] forced to 0.
  - out_flush=1 for one cycle, out_inst_valid<=0, and the skid entry is cleared.
- Redirect in FETCH with an ack in the same cycle: the response is discarded, and the state stays in FETCH at the new pc.
- Redirect in FETCH without an ack: the current addr is latched as drain_addr, and the state moves to DRAIN.
- DRAIN: req=1, addr=drain_addr. On ack the response is discarded and the state moves to FETCH. A further redirect in DRAIN updates pc and pulses flush, with no other change.
- Redirect in HOLD: the skid entry is dropped, and the state moves to FETCH.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0.

## Timing
- Reset values (in_rst_n=0 sampled at an edge):
  - state=BOOT, out_pc=RESET_PC.
  - out_imem_req=0, out_inst=0, out_inst_pc=0, out_inst_valid=0, out_flush=0.
- Reset mid-request: the outstanding request is abandoned. A late ack in BOOT is ignored.
- out_imem_req, out_imem_addr and out_flush decode combinationally from state and registers. They never depend combinationally on ack.
- First request is in cycle 1 after reset release.
- Zero-wait memory: request in cycle N gives out_inst_valid in N+1. Sustained throughput is 1 instruction/cycle.
- Redirect in cycle N: out_flush is high during N+1. The first request to the target is in N+1 from FETCH, or in the cycle after the drain ack from DRAIN.

## Configuration
- FETCH_EXC_EN defined: in_exc and in_eret redirects operate as specified above.
- FETCH_EXC_EN undefined:
  - in_exc, in_eret and in_epc stay as ports but are ignored.
  - EXC_VEC is unused.
  - Redirect priority is jmp > branch.

## Test plan
- Reset release with zero-wait memory, ack=1 every cycle -> request addresses 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; out_inst_pc follows one cycle later, with valid=1 from cycle 2.
- in_stall=1 for 3 cycles during an ack -> outputs frozen, req=0 after the capture; on release, the skid instruction appears once with no duplicate and no loss.
- Jump to 0x00400100 while the memory has 2 wait states outstanding -> DRAIN holds addr until the ack, the response is discarded, flush pulses once, and the next request is to 0x00400100.
- Simultaneous in_jmp and in_br_taken, targets 0x400200 and 0x400300 -> fetch resumes at 0x400200.
- With FETCH_EXC_EN: in_exc together with in_jmp -> pc=EXC_VEC. Then in_eret with in_epc=0x00400010 -> fetch resumes at 0x00400010. Without the macro, in_exc has no effect.
- pc=0xFFFFFFFC with an ack -> next request is to 0x00000000. Target 0x00400103 -> request to 0x00400100.
